alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the 16-bit ALU in the custom processor datapath.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal register file.
- Registers operands and op select into an EX stage that drives the ALU inputs, then writes the ALU result back to the register file one cycle later.
- Forwards the in-flight EX result so back-to-back dependent instructions never stall.

Parameters:
- NREGS, 8, number of 16-bit architectural registers (r0 hardwired to zero); must be 8 to match the 3-bit register fields.
- IMM_W, 7, immediate field width; sign-extended to 16 bits.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept an instruction this cycle
- instr  in  16  fields: [15:14] op, [13:11] rd, [10:8] rs1, [7] imm_sel, [6:4] rs2, [6:0] imm7
- stall  in  1  external hold request from the control unit
- alu_in1  out  16  ALU operand 1 (registered)
- alu_in2  out  16  ALU operand 2 (registered)
- alu_con_sig  out  2  ALU op select (registered): 00 add, 10 and, 11 or
- alu_out  in  16  combinational ALU result for the current EX operands
- wb_valid  out  1  pulse: a register-file write occurred at the last edge
- wb_rd  out  3  register written
- wb_data  out  16  value written
- illegal_op  out  1  pulse, one cycle: an op=01 instruction was accepted

Behaviour:
- Reset is synchronous, active-low, on the clk edge with rst_n=0:
  - all registers cleared to 0; ex_valid=0
  - alu_in1, alu_in2, alu_con_sig, wb_valid, wb_rd, wb_data, illegal_op all 0
  - instr_ready=0 while rst_n=0
  - an instruction in flight when reset asserts is discarded with no writeback
- instr_ready = rst_n & ~stall (combinational). Accept on instr_valid & instr_ready.
- Cycle N (accept):
  - Read rs1, and rs2 when imm_sel=0. r0 reads as 0.
  - Forwarding: if ex_valid & ex_wen & ex_rd==rs & rs!=0, the operand takes alu_out instead of the register-file value.
  - Edge at end of N loads ex_valid=1, ex_op=op, ex_rd=rd, alu_in1=op1.
  - alu_in2 is loaded with imm_sel ? sign_extend(imm7) : op2.
- Cycle N+1 (EX): ALU computes. At the edge ending N+1, if ex_wen:
  - rf[ex_rd] <= alu_out
  - wb_valid=1, wb_rd=ex_rd, wb_data=alu_out
- Writeback latency: 2 edges after accept. Throughput: 1 instruction per cycle.
- No accept in a cycle: ex_valid clears; alu_in1, alu_in2 and alu_con_sig hold their last values.
- Write enable: ex_wen = ex_valid & op!=01 & rd!=0. Writes to r0 are discarded and produce wb_valid=0.
- op=01 (illegal):
  - illegal_op pulses at the edge ending N
  - alu_con_sig is set to 00
  - no writeback and no forwarding
- stall=1 blocks new accepts only; the instruction already in EX still completes its writeback.
- Read and write to the same register in one cycle: the forwarding path supplies the new value.

Optional Feature:
- Macro ALU_ISSUE_DBG_EN.
- Defined: adds ports dbg_addr (in, 3) and dbg_data (out, 16), an asynchronous read of the register file with no forwarding; r0 reads 0.
- Undefined: the ports are absent and there is no extra logic.

Decomposition:
- Shared package alu_issue_pkg:
  - opcode constants OP_ADD=2'b00, OP_ILL=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - instruction field bit positions
  - NREGS, REG_W=16
- One sub-module: issue_regfile, with 2 async read ports, 1 sync write port, and r0 hardwired to 0.
- alu_issue_stage holds the handshake, forwarding muxes, EX register and writeback register.

Test Plan:
- Reset, then imm-add with r1=0+5 (op=00, rd=1, rs1=0, imm_sel=1, imm7=5) -> 2 edges later wb_valid=1, wb_rd=1, wb_data=0x0005.
- Back-to-back forwarding: r1=5, then r2=r1+r1 the next cycle -> alu_in1=alu_in2=0x0005 with no stall; wb_data=0x000A.
- Negative immediate: r3=r0+imm7 0x7F -> alu_in2=0xFFFF, wb_data=0xFFFF; then AND of r3 with r1 (r1=5) -> 0x0005; OR of r3 with r0 -> 0xFFFF.
- Illegal op: op=01, rd=4 -> illegal_op single pulse, no wb_valid; a later read of r4 returns 0.
- Stall: stall=1 with instr_valid=1 -> instr_ready=0 and nothing accepted; the EX instruction still writes back; accept resumes on the cycle stall drops.
- Write to r0 with value 0x1234 -> wb_valid stays 0; a following instruction reading r0 sees 0 (no forwarding). Reset asserted mid-flight -> no writeback, all outputs 0 the next cycle.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU operand-issue stage: opcodes, instruction field
// positions, register-file geometry and the immediate sign-extension helper.
package alu_issue_pkg;

  localparam int NREGS = 8;
  localparam int REG_W = 16;
  localparam int IMM_W = 7;
  localparam int RA_W  = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ILL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // instr: [15:14] op, [13:11] rd, [10:8] rs1, [7] imm_sel, [6:4] rs2 / [6:0] imm7
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 14;
  localparam int RD_HI   = 13;
  localparam int RD_LO   = 11;
  localparam int RS1_HI  = 10;
  localparam int RS1_LO  = 8;
  localparam int ISEL_B  = 7;
  localparam int RS2_HI  = 6;
  localparam int RS2_LO  = 4;
  localparam int IMM_HI  = 6;
  localparam int IMM_LO  = 0;

  function automatic logic [REG_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(REG_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero. ALU_ISSUE_DBG_EN adds a third read port.
module issue_regfile
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  i_raddr1,
  input  logic [RA_W-1:0]  i_raddr2,
  output logic [REG_W-1:0] o_rdata1,
  output logic [REG_W-1:0] o_rdata2,
  input  logic             i_we,
  input  logic [RA_W-1:0]  i_waddr,
  input  logic [REG_W-1:0] i_wdata
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [RA_W-1:0]  i_dbg_addr,
  output logic [REG_W-1:0] o_dbg_data
`endif
);

  logic [REG_W-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

`ifdef ALU_ISSUE_DBG_EN
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding the 16-bit ALU: handshake, EX-result forwarding,
// EX register and writeback register. ALU_ISSUE_DBG_EN adds dbg_addr/dbg_data.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic             stall,
  output logic [REG_W-1:0] alu_in1,
  output logic [REG_W-1:0] alu_in2,
  output logic [1:0]       alu_con_sig,
  input  logic [REG_W-1:0] alu_out,
  output logic             wb_valid,
  output logic [RA_W-1:0]  wb_rd,
  output logic [REG_W-1:0] wb_data,
  output logic             illegal_op
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [REG_W-1:0] dbg_data
`endif
);

  logic [1:0]       w_op;
  logic [RA_W-1:0]  w_rd, w_rs1, w_rs2;
  logic             w_imm_sel;
  logic [IMM_W-1:0] w_imm;
  logic             w_accept, w_ex_wen;
  logic [REG_W-1:0] w_rf_rd1, w_rf_rd2, w_op1, w_op2;

  logic             r_ex_valid;
  logic [1:0]       r_ex_op;
  logic [RA_W-1:0]  r_ex_rd;
  logic [REG_W-1:0] r_alu_in1, r_alu_in2;
  logic [1:0]       r_alu_con;
  logic             r_wb_valid;
  logic [RA_W-1:0]  r_wb_rd;
  logic [REG_W-1:0] r_wb_data;
  logic             r_illegal;

  assign w_op      = instr[OP_HI:OP_LO];
  assign w_rd      = instr[RD_HI:RD_LO];
  assign w_rs1     = instr[RS1_HI:RS1_LO];
  assign w_imm_sel = instr[ISEL_B];
  assign w_rs2     = instr[RS2_HI:RS2_LO];
  assign w_imm     = instr[IMM_HI:IMM_LO];

  assign instr_ready = rst_n & ~stall;
  assign w_accept    = instr_valid & instr_ready;
  assign w_ex_wen    = r_ex_valid & (r_ex_op != OP_ILL) & (r_ex_rd != '0);

  issue_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2),
    .i_we     (w_ex_wen),
    .i_waddr  (r_ex_rd),
    .i_wdata  (alu_out)
`ifdef ALU_ISSUE_DBG_EN
    ,
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
`endif
  );

  // The EX result is only committed at the next edge, so a dependent read takes it live.
  assign w_op1 = (w_ex_wen && (r_ex_rd == w_rs1) && (w_rs1 != '0)) ? alu_out : w_rf_rd1;
  assign w_op2 = (w_ex_wen && (r_ex_rd == w_rs2) && (w_rs2 != '0)) ? alu_out : w_rf_rd2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= OP_ADD;
      r_ex_rd    <= '0;
      r_alu_in1  <= '0;
      r_alu_in2  <= '0;
      r_alu_con  <= OP_ADD;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_ex_valid <= w_accept;
      r_illegal  <= w_accept && (w_op == OP_ILL);
      if (w_accept) begin
        r_ex_op   <= w_op;
        r_ex_rd   <= w_rd;
        r_alu_in1 <= w_op1;
        r_alu_in2 <= w_imm_sel ? sext_imm(w_imm) : w_op2;
        r_alu_con <= (w_op == OP_AND || w_op == OP_OR) ? w_op : OP_ADD;
      end
      r_wb_valid <= w_ex_wen;
      if (w_ex_wen) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= alu_out;
      end
    end
  end

  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign alu_con_sig = r_alu_con;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: architectural register model predicts
// every writeback; a negedge monitor pops and compares.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        stall;
  logic [15:0] alu_in1, alu_in2;
  logic [1:0]  alu_con_sig;
  logic [15:0] alu_out;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal_op;

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .stall       (stall),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_con_sig (alu_con_sig),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  // Downstream ALU: 00 add, 10 and, 11 or
  always_comb begin
    case (alu_con_sig)
      2'b10:   alu_out = alu_in1 & alu_in2;
      2'b11:   alu_out = alu_in1 | alu_in2;
      default: alu_out = alu_in1 + alu_in2;
    endcase
  end

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_e;
  logic [15:0] mrf [8];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          ill_exp = 0;
  int          ill_seen = 0;

  localparam logic [1:0] ADD = 2'b00, ILL = 2'b01, AND_ = 2'b10, OR_ = 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc_i(input logic [1:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [6:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [1:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 4'b0000};
  endfunction

  // Sequential ISA semantics: each accepted instruction sees all earlier results.
  task automatic model_apply(input logic [15:0] ins);
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b, r;
    wb_t         e;
    op = ins[15:14];
    rd = ins[13:11];
    if (op == ILL) begin
      ill_exp++;
    end else begin
      a = mrf[ins[10:8]];
      b = ins[7] ? {{9{ins[6]}}, ins[6:0]} : mrf[ins[6:4]];
      case (op)
        AND_:    r = a & b;
        OR_:     r = a | b;
        default: r = a + b;
      endcase
      if (rd != 3'd0) begin
        mrf[rd] = r;
        e.rd = rd;
        e.data = r;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic stl);
    instr = ins;
    instr_valid = 1'b1;
    stall = stl;
    if (!stl && rst_n) model_apply(ins);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    stall = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {29'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd", {29'd0, wb_rd}, {29'd0, mon_e.rd});
        chk("wb_data", {16'd0, wb_data}, {16'd0, mon_e.data});
      end
    end
    if (illegal_op) ill_seen++;
  end

  initial begin
    logic [15:0] ins;
    logic [1:0]  rop;
    int          sel;
    for (int i = 0; i < 8; i++) mrf[i] = 16'd0;
    rst_n = 1'b0;
    instr_valid = 1'b1;
    stall = 1'b0;
    instr = enc_i(ADD, 3'd1, 3'd0, 7'd9);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 0);
    chk("rst_in1", {16'd0, alu_in1}, 0);
    chk("rst_in2", {16'd0, alu_in2}, 0);
    chk("rst_con", {30'd0, alu_con_sig}, 0);
    chk("rst_wbv", {31'd0, wb_valid}, 0);
    chk("rst_wbrd", {29'd0, wb_rd}, 0);
    chk("rst_wbdata", {16'd0, wb_data}, 0);
    chk("rst_ill", {31'd0, illegal_op}, 0);
    rst_n = 1'b1;
    instr_valid = 1'b0;

    // r1 = r0 + 5, then r2 = r1 + r1 back-to-back
    issue(enc_i(ADD, 3'd1, 3'd0, 7'd5), 1'b0);
    chk("imm_in1", {16'd0, alu_in1}, 0);
    chk("imm_in2", {16'd0, alu_in2}, 16'h0005);
    chk("imm_con", {30'd0, alu_con_sig}, 0);
    issue(enc_r(ADD, 3'd2, 3'd1, 3'd1), 1'b0);
    chk("imm_wbv", {31'd0, wb_valid}, 1);
    chk("imm_wbrd", {29'd0, wb_rd}, 1);
    chk("imm_wbdata", {16'd0, wb_data}, 16'h0005);
    chk("fwd_in1", {16'd0, alu_in1}, 16'h0005);
    chk("fwd_in2", {16'd0, alu_in2}, 16'h0005);
    idle();
    chk("fwd_wbrd", {29'd0, wb_rd}, 2);
    chk("fwd_wbdata", {16'd0, wb_data}, 16'h000A);

    // negative immediate, AND, OR, then illegal op
    issue(enc_i(ADD, 3'd3, 3'd0, 7'h7F), 1'b0);
    chk("neg_in2", {16'd0, alu_in2}, 16'hFFFF);
    issue(enc_r(AND_, 3'd5, 3'd3, 3'd1), 1'b0);
    chk("neg_wbdata", {16'd0, wb_data}, 16'hFFFF);
    chk("and_in1", {16'd0, alu_in1}, 16'hFFFF);
    issue(enc_r(OR_, 3'd6, 3'd3, 3'd0), 1'b0);
    chk("and_wbdata", {16'd0, wb_data}, 16'h0005);
    chk("or_con", {30'd0, alu_con_sig}, 2'b11);
    issue(enc_i(ILL, 3'd4, 3'd1, 7'd3), 1'b0);
    chk("or_wbdata", {16'd0, wb_data}, 16'hFFFF);
    chk("ill_pulse", {31'd0, illegal_op}, 1);
    chk("ill_con", {30'd0, alu_con_sig}, 0);
    idle();
    chk("ill_pulse_end", {31'd0, illegal_op}, 0);
    chk("ill_no_wb", {31'd0, wb_valid}, 0);
    issue(enc_i(ADD, 3'd7, 3'd4, 7'd0), 1'b0);
    idle();
    chk("ill_r4_wbv", {31'd0, wb_valid}, 1);
    chk("ill_r4_data", {16'd0, wb_data}, 0);

    // stall holds off new accepts while EX still writes back
    instr = enc_i(ADD, 3'd2, 3'd1, 7'd1);
    instr_valid = 1'b1;
    stall = 1'b0;
    model_apply(instr);
    @(posedge clk); #1;
    instr = enc_i(ADD, 3'd3, 3'd2, 7'd1);
    stall = 1'b1;
    #1;
    chk("stall_ready", {31'd0, instr_ready}, 0);
    @(posedge clk); #1;
    chk("stall_wbv", {31'd0, wb_valid}, 1);
    chk("stall_wbdata", {16'd0, wb_data}, 16'h0006);
    @(posedge clk); #1;
    chk("stall_nowb", {31'd0, wb_valid}, 0);
    chk("stall_hold1", {16'd0, alu_in1}, 16'h0005);
    chk("stall_hold2", {16'd0, alu_in2}, 16'h0001);
    stall = 1'b0;
    model_apply(instr);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("resume_in1", {16'd0, alu_in1}, 16'h0006);
    idle();
    chk("resume_wbdata", {16'd0, wb_data}, 16'h0007);

    // build 0x1234 in r1, write it to r0, read r0 straight after
    issue(enc_i(ADD, 3'd1, 3'd0, 7'h24), 1'b0);
    for (int i = 0; i < 7; i++) issue(enc_r(ADD, 3'd1, 3'd1, 3'd1), 1'b0);
    issue(enc_i(ADD, 3'd1, 3'd1, 7'h34), 1'b0);
    issue(enc_i(ADD, 3'd0, 3'd1, 7'd0), 1'b0);
    chk("r0_alu", {16'd0, alu_out}, 16'h1234);
    issue(enc_r(OR_, 3'd2, 3'd0, 3'd0), 1'b0);
    chk("r0_nowb", {31'd0, wb_valid}, 0);
    chk("r0_in1", {16'd0, alu_in1}, 0);
    chk("r0_in2", {16'd0, alu_in2}, 0);
    idle();
    chk("r0_read_data", {16'd0, wb_data}, 0);

    // randomized traffic with stalls, bubbles and illegal ops
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      rop = (sel == 0) ? ILL : (sel < 5) ? ADD : (sel < 8) ? AND_ : OR_;
      ins = {rop, 3'($urandom_range(0, 7)), 11'($urandom)};
      if ($urandom_range(0, 5) == 0) idle();
      else issue(ins, ($urandom_range(0, 4) == 0));
    end
    repeat (3) idle();
    chk("drain_empty", exp_q.size(), 0);
    chk("ill_count", ill_seen, ill_exp);

    // reset with an instruction in EX: it must never write back
    issue(enc_i(ADD, 3'd5, 3'd0, 7'h11), 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) mrf[i] = 16'd0;
    @(posedge clk); #1;
    chk("mrst_ready", {31'd0, instr_ready}, 0);
    chk("mrst_wbv", {31'd0, wb_valid}, 0);
    chk("mrst_wbrd", {29'd0, wb_rd}, 0);
    chk("mrst_wbdata", {16'd0, wb_data}, 0);
    chk("mrst_in1", {16'd0, alu_in1}, 0);
    chk("mrst_in2", {16'd0, alu_in2}, 0);
    chk("mrst_con", {30'd0, alu_con_sig}, 0);
    chk("mrst_ill", {31'd0, illegal_op}, 0);
    rst_n = 1'b1;
    issue(enc_r(OR_, 3'd6, 3'd5, 3'd5), 1'b0);
    idle();
    chk("mrst_rf_clear", {16'd0, wb_data}, 0);
    idle();
    chk("final_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
